// File: rtl/snn_axi_pkg.sv
// Shared types and constants for the SNN AXI-lite image interface.
// The optional IRQ feature is selected by the S_AXI_IMAGE_IRQ_EN macro.
package snn_axi_pkg;

  typedef enum logic [1:0] {
    W_IDLE    = 2'd0,
    W_ADDR_OK = 2'd1,
    W_DATA_OK = 2'd2,
    W_RESP    = 2'd3
  } wr_state_t;

  typedef enum logic [2:0] {
    REG_IMAGE  = 3'd0,
    REG_CTRL   = 3'd1,
    REG_STATUS = 3'd2,
    REG_RESULT = 3'd3,
    REG_BAD    = 3'd4
  } reg_sel_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int CTRL_START_BIT    = 0;
  localparam int CTRL_IRQ_EN_BIT   = 1;
  localparam int CTRL_CLR_DONE_BIT = 2;

  localparam int STAT_DONE_BIT = 0;
  localparam int STAT_BUSY_BIT = 1;
  localparam int STAT_IRQ_BIT  = 2;

endpackage

// File: rtl/axi_lite_wr_ctrl.sv
// AXI-lite write-channel FSM: accepts AW and W in any order, emits one
// commit strobe per write and holds the B response until BREADY.
module axi_lite_wr_ctrl
  import snn_axi_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                en,
  input  logic [ADDR_W-1:0]   awaddr,
  input  logic                awvalid,
  output logic                awready,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  input  logic                wvalid,
  output logic                wready,
  output logic [1:0]          bresp,
  output logic                bvalid,
  input  logic                bready,
  input  logic [1:0]          commit_resp,
  output logic                commit,
  output logic [ADDR_W-1:0]   commit_addr,
  output logic [DATA_W-1:0]   commit_data,
  output logic [DATA_W/8-1:0] commit_strb,
  output wr_state_t           state
);

  // Handshake rule: a channel transfers on the rising CLK edge where its
  // VALID and READY are both high; VALID never waits for READY.
  wr_state_t             state_nxt;
  logic [ADDR_W-1:0]     addr_q;
  logic [DATA_W-1:0]     data_q;
  logic [DATA_W/8-1:0]   strb_q;
  logic [1:0]            bresp_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= W_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      W_IDLE: begin
        if (awvalid && awready && wvalid && wready) state_nxt = W_RESP;
        else if (awvalid && awready)                state_nxt = W_ADDR_OK;
        else if (wvalid && wready)                  state_nxt = W_DATA_OK;
      end
      W_ADDR_OK: if (wvalid && wready)   state_nxt = W_RESP;
      W_DATA_OK: if (awvalid && awready) state_nxt = W_RESP;
      W_RESP:    if (bready)             state_nxt = W_IDLE;
      default:   state_nxt = W_IDLE;
    endcase
  end

  always_comb begin
    awready     = 1'b0;
    wready      = 1'b0;
    bvalid      = 1'b0;
    commit      = 1'b0;
    commit_addr = awaddr;
    commit_data = wdata;
    commit_strb = wstrb;
    case (state)
      W_IDLE: begin
        awready = en;
        wready  = en;
        commit  = en && awvalid && wvalid;
      end
      W_ADDR_OK: begin
        wready      = en;
        commit      = en && wvalid;
        commit_addr = addr_q;
      end
      W_DATA_OK: begin
        awready     = en;
        commit      = en && awvalid;
        commit_data = data_q;
        commit_strb = strb_q;
      end
      W_RESP:  bvalid = 1'b1;
      default: bvalid = 1'b0;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      addr_q  <= '0;
      data_q  <= '0;
      strb_q  <= '0;
      bresp_q <= RESP_OKAY;
    end else begin
      if (awvalid && awready) addr_q <= awaddr;
      if (wvalid && wready) begin
        data_q <= wdata;
        strb_q <= wstrb;
      end
      if (commit) bresp_q <= commit_resp;
    end
  end

  assign bresp = bresp_q;

endmodule

// File: rtl/s_axi_packed_image_if.sv
// AXI-lite slave holding a packed pixel image for the SNN core, with CTRL/STATUS/RESULT
// registers. Define S_AXI_IMAGE_IRQ_EN to add the IRQ output and CTRL irq/clear bits.
module s_axi_packed_image_if
  import snn_axi_pkg::*;
#(
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int IMAGE_SIZE     = 256,
  parameter int PIXEL_BITS     = 8
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic [AXI_ADDR_WIDTH-1:0]     AWADDR,
  input  logic                          AWVALID,
  output logic                          AWREADY,
  input  logic [AXI_DATA_WIDTH-1:0]     WDATA,
  input  logic [AXI_DATA_WIDTH/8-1:0]   WSTRB,
  input  logic                          WVALID,
  output logic                          WREADY,
  output logic [1:0]                    BRESP,
  output logic                          BVALID,
  input  logic                          BREADY,
  input  logic [AXI_ADDR_WIDTH-1:0]     ARADDR,
  input  logic                          ARVALID,
  output logic                          ARREADY,
  output logic [AXI_DATA_WIDTH-1:0]     RDATA,
  output logic [1:0]                    RRESP,
  output logic                          RVALID,
  input  logic                          RREADY,
  input  logic                          COPROCESSOR_RDY,
  input  logic [7:0]                    INFERED_DIGIT,
  output logic [IMAGE_SIZE*PIXEL_BITS-1:0] IMAGE,
  output logic                          NEW_IMAGE,
  output logic                          BUSY,
`ifdef S_AXI_IMAGE_IRQ_EN
  output logic                          IRQ,
`endif
  output wr_state_t                     DBG_WR_STATE
);

  localparam int PIXELS_PER_WORD = AXI_DATA_WIDTH / 8;
  localparam int IMAGE_WORDS     = IMAGE_SIZE / PIXELS_PER_WORD;
  localparam logic [AXI_ADDR_WIDTH-1:0] CTRL_IDX   = AXI_ADDR_WIDTH'(IMAGE_WORDS);
  localparam logic [AXI_ADDR_WIDTH-1:0] STATUS_IDX = AXI_ADDR_WIDTH'(IMAGE_WORDS + 1);
  localparam logic [AXI_ADDR_WIDTH-1:0] RESULT_IDX = AXI_ADDR_WIDTH'(IMAGE_WORDS + 2);

  function automatic reg_sel_t decode(input logic [AXI_ADDR_WIDTH-1:0] addr);
    logic [AXI_ADDR_WIDTH-1:0] widx;
    widx = addr >> 2;
    if (widx < CTRL_IDX)         return REG_IMAGE;
    else if (widx == CTRL_IDX)   return REG_CTRL;
    else if (widx == STATUS_IDX) return REG_STATUS;
    else if (widx == RESULT_IDX) return REG_RESULT;
    else                         return REG_BAD;
  endfunction

  logic [IMAGE_SIZE*PIXEL_BITS-1:0] image_q;
  logic                             live_q;
  logic                             wr_commit;
  logic [AXI_ADDR_WIDTH-1:0]        wr_addr;
  logic [AXI_DATA_WIDTH-1:0]        wr_data;
  logic [AXI_DATA_WIDTH/8-1:0]      wr_strb;
  reg_sel_t                         wr_sel;
  logic [1:0]                       wr_resp;
  int                               wr_word;
  logic new_image_q, busy_q, done_q, rdy_q;
  logic [7:0] digit_q;
  logic start, latch, rd_clear, ctrl_clear, irq_pending;

  // Holds all READY outputs low until the first edge after reset is released.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) live_q <= 1'b0;
    else     live_q <= 1'b1;
  end

  axi_lite_wr_ctrl #(.ADDR_W(AXI_ADDR_WIDTH), .DATA_W(AXI_DATA_WIDTH)) u_wr (
    .CLK(CLK), .RST(RST), .en(live_q),
    .awaddr(AWADDR), .awvalid(AWVALID), .awready(AWREADY),
    .wdata(WDATA), .wstrb(WSTRB), .wvalid(WVALID), .wready(WREADY),
    .bresp(BRESP), .bvalid(BVALID), .bready(BREADY),
    .commit_resp(wr_resp), .commit(wr_commit), .commit_addr(wr_addr),
    .commit_data(wr_data), .commit_strb(wr_strb), .state(DBG_WR_STATE)
  );

  assign wr_sel  = decode(wr_addr);
  assign wr_resp = (wr_sel == REG_BAD) ? RESP_SLVERR : RESP_OKAY;
  assign wr_word = int'(wr_addr >> 2);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      image_q <= '0;
    end else if (wr_commit && wr_sel == REG_IMAGE) begin
      for (int i = 0; i < IMAGE_SIZE; i++)
        if (i / PIXELS_PER_WORD == wr_word && wr_strb[i % PIXELS_PER_WORD])
          image_q[i*PIXEL_BITS +: PIXEL_BITS] <= wr_data[(i % PIXELS_PER_WORD)*8 +: PIXEL_BITS];
    end
  end

  assign start = wr_commit && wr_sel == REG_CTRL && wr_data[CTRL_START_BIT] && !busy_q;
  assign latch = COPROCESSOR_RDY && !rdy_q && busy_q;

`ifdef S_AXI_IMAGE_IRQ_EN
  logic irq_en_q;
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                                  irq_en_q <= 1'b0;
    else if (wr_commit && wr_sel == REG_CTRL) irq_en_q <= wr_data[CTRL_IRQ_EN_BIT];
  end
  assign ctrl_clear  = wr_commit && wr_sel == REG_CTRL && wr_data[CTRL_CLR_DONE_BIT];
  assign irq_pending = done_q && irq_en_q;
  assign IRQ         = irq_pending;
`else
  assign ctrl_clear  = 1'b0;
  assign irq_pending = 1'b0;
`endif

  // A result latch outranks every clear source in the same cycle.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rdy_q       <= 1'b0;
      new_image_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      digit_q     <= '0;
    end else begin
      rdy_q       <= COPROCESSOR_RDY;
      new_image_q <= start;
      if (start)      busy_q <= 1'b1;
      else if (latch) busy_q <= 1'b0;
      if (latch) begin
        done_q  <= 1'b1;
        digit_q <= INFERED_DIGIT;
      end else if (start || rd_clear || ctrl_clear) begin
        done_q <= 1'b0;
      end
    end
  end

  assign IMAGE     = image_q;
  assign NEW_IMAGE = new_image_q;
  assign BUSY      = busy_q;

  logic                      rvalid_q, rd_result_q;
  logic [AXI_DATA_WIDTH-1:0] rdata_q, rd_data;
  logic [1:0]                rresp_q;
  reg_sel_t                  rd_sel;
  int                        rd_word;
  logic [31:0]               status_word, result_word;

  assign rd_sel      = decode(ARADDR);
  assign rd_word     = int'(ARADDR >> 2);
  assign status_word = {29'b0, irq_pending, busy_q, done_q};
  assign result_word = {done_q, 23'b0, digit_q};

  always_comb begin
    rd_data = '0;
    case (rd_sel)
      REG_IMAGE: begin
        for (int i = 0; i < IMAGE_SIZE; i++)
          if (i / PIXELS_PER_WORD == rd_word)
            rd_data[(i % PIXELS_PER_WORD)*8 +: PIXEL_BITS] = image_q[i*PIXEL_BITS +: PIXEL_BITS];
      end
      REG_STATUS: rd_data = AXI_DATA_WIDTH'(status_word);
      REG_RESULT: rd_data = AXI_DATA_WIDTH'(result_word);
      default:    rd_data = '0;
    endcase
  end

  assign ARREADY  = live_q && !rvalid_q;
  assign rd_clear = rvalid_q && RREADY && rd_result_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rvalid_q    <= 1'b0;
      rdata_q     <= '0;
      rresp_q     <= RESP_OKAY;
      rd_result_q <= 1'b0;
    end else if (ARVALID && ARREADY) begin
      rvalid_q    <= 1'b1;
      rdata_q     <= rd_data;
      rresp_q     <= (rd_sel == REG_BAD) ? RESP_SLVERR : RESP_OKAY;
      rd_result_q <= (rd_sel == REG_RESULT);
    end else if (rvalid_q && RREADY) begin
      rvalid_q <= 1'b0;
    end
  end

  assign RVALID = rvalid_q;
  assign RDATA  = rdata_q;
  assign RRESP  = rresp_q;

endmodule

// File: tb/tb_s_axi_packed_image_if.sv
// Scoreboard bench for s_axi_packed_image_if: random AXI-lite traffic checked
// against a pixel-array/register model of the interface.
`timescale 1ns/1ps
module tb_s_axi_packed_image_if;
  import snn_axi_pkg::*;

  localparam int IMG = 256;
  localparam int WORDS = 64;
  localparam logic [31:0] C_ADDR = 32'h100;
  localparam logic [31:0] S_ADDR = 32'h104;
  localparam logic [31:0] R_ADDR = 32'h108;

  logic CLK, RST;
  logic [31:0] AWADDR, WDATA, ARADDR, RDATA;
  logic [3:0] WSTRB;
  logic AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
  logic ARVALID, ARREADY, RVALID, RREADY;
  logic [1:0] BRESP, RRESP;
  logic COPROCESSOR_RDY;
  logic [7:0] INFERED_DIGIT;
  logic [IMG*8-1:0] IMAGE;
  logic NEW_IMAGE, BUSY;
`ifdef S_AXI_IMAGE_IRQ_EN
  logic IRQ;
`endif
  wr_state_t dbg_state;

  s_axi_packed_image_if dut (
    .CLK(CLK), .RST(RST),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
    .COPROCESSOR_RDY(COPROCESSOR_RDY), .INFERED_DIGIT(INFERED_DIGIT),
    .IMAGE(IMAGE), .NEW_IMAGE(NEW_IMAGE), .BUSY(BUSY),
`ifdef S_AXI_IMAGE_IRQ_EN
    .IRQ(IRQ),
`endif
    .DBG_WR_STATE(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #1000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [1:0]  exp_b_q[$];
  logic [33:0] exp_r_q[$];
  logic [1:0]  eb;
  logic [33:0] er;
  int ni_count = 0;

  logic [7:0] m_img [IMG];
  bit         m_busy, m_done, m_irq_en;
  logic [7:0] m_digit;
  int         m_ni = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic check_image(input string name);
    int bad;
    bad = -1;
    for (int i = 0; i < IMG; i++)
      if (bad < 0 && IMAGE[i*8 +: 8] !== m_img[i]) bad = i;
    checks++;
    if (bad >= 0) begin
      errors++;
      $display("FAIL %s pixel %0d got %0h want %0h", name, bad, IMAGE[bad*8 +: 8], m_img[bad]);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < IMG; i++) m_img[i] = 8'h00;
    m_busy = 0; m_done = 0; m_irq_en = 0; m_digit = 8'h00;
  endtask

  task automatic model_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, output logic [1:0] resp);
    int w;
    w = int'(addr >> 2);
    resp = RESP_OKAY;
    if (w < WORDS) begin
      for (int k = 0; k < 4; k++) if (strb[k]) m_img[w*4 + k] = data[8*k +: 8];
    end else if (w == WORDS) begin
`ifdef S_AXI_IMAGE_IRQ_EN
      m_irq_en = data[1];
      if (data[2]) m_done = 0;
`endif
      if (data[0] && !m_busy) begin m_busy = 1; m_done = 0; m_ni++; end
    end else if (w > WORDS + 2) begin
      resp = RESP_SLVERR;
    end
  endtask

  task automatic model_read(input logic [31:0] addr, output logic [33:0] e);
    int w;
    w = int'(addr >> 2);
    if (w < WORDS)            e = {RESP_OKAY, m_img[w*4+3], m_img[w*4+2], m_img[w*4+1], m_img[w*4]};
    else if (w == WORDS + 1)  e = {RESP_OKAY, 29'd0, m_done & m_irq_en, m_busy, m_done};
    else if (w == WORDS + 2)  begin e = {RESP_OKAY, m_done, 23'd0, m_digit}; m_done = 0; end
    else if (w == WORDS)      e = {RESP_OKAY, 32'd0};
    else                      e = {RESP_SLVERR, 32'd0};
  endtask

  // ---------------- monitor ----------------
  always @(negedge CLK) begin
    if (!RST) begin
      if (NEW_IMAGE) ni_count++;
      if (BVALID && BREADY) begin
        if (exp_b_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL bresp unexpected response %0h", BRESP);
        end else begin
          eb = exp_b_q.pop_front();
          check("bresp", {62'd0, BRESP}, {62'd0, eb});
        end
      end
      if (RVALID && RREADY) begin
        if (exp_r_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL rdata unexpected response %0h", RDATA);
        end else begin
          er = exp_r_q.pop_front();
          check("rdata", {32'd0, RDATA}, {32'd0, er[31:0]});
          check("rresp", {62'd0, RRESP}, {62'd0, er[33:32]});
        end
      end
    end
  end

  // ---------------- drivers ----------------
  // order: 0 = AW and W together, 1 = AW first, 2 = W first
  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int order, input bit hold_b);
    logic [1:0] r;
    bit aw_left, w_left, aw_hs, w_hs;
    int n;
    model_write(addr, data, strb, r);
    exp_b_q.push_back(r);
    AWADDR = addr; WDATA = data; WSTRB = strb;
    aw_left = 1; w_left = 1;
    AWVALID = (order != 2);
    WVALID  = (order != 1);
    n = 0;
    while ((aw_left || w_left) && n < 50) begin
      aw_hs = AWVALID && AWREADY;
      w_hs  = WVALID && WREADY;
      @(posedge CLK); #1; n++;
      if (aw_hs) begin AWVALID = 0; aw_left = 0; end
      if (w_hs)  begin WVALID = 0;  w_left = 0;  end
      if (order == 1 && !aw_left && w_left) WVALID = 1;
      if (order == 2 && !w_left && aw_left) AWVALID = 1;
    end
    if (aw_left || w_left) begin
      checks++; errors++;
      $display("FAIL write_handshake timeout addr %0h", addr);
      AWVALID = 0; WVALID = 0;
    end
    n = 0;
    while (!BVALID && n < 50) begin @(posedge CLK); #1; n++; end
    if (!BVALID) begin
      checks++; errors++;
      $display("FAIL bvalid timeout addr %0h", addr);
      void'(exp_b_q.pop_back());
    end else if (!hold_b) begin
      repeat ($urandom_range(0, 2)) begin @(posedge CLK); #1; end
      BREADY = 1;
      @(posedge CLK); #1;
      BREADY = 0;
    end
  endtask

  task automatic axi_read(input logic [31:0] addr);
    logic [33:0] e;
    int n;
    model_read(addr, e);
    exp_r_q.push_back(e);
    ARADDR = addr; ARVALID = 1;
    n = 0;
    while (!ARREADY && n < 50) begin @(posedge CLK); #1; n++; end
    @(posedge CLK); #1;
    ARVALID = 0;
    n = 0;
    while (!RVALID && n < 50) begin @(posedge CLK); #1; n++; end
    if (!RVALID) begin
      checks++; errors++;
      $display("FAIL rvalid timeout addr %0h", addr);
      void'(exp_r_q.pop_back());
    end else begin
      repeat ($urandom_range(0, 2)) begin @(posedge CLK); #1; end
      RREADY = 1;
      @(posedge CLK); #1;
      RREADY = 0;
    end
  endtask

  task automatic rdy_pulse(input logic [7:0] digit);
    INFERED_DIGIT = digit;
    COPROCESSOR_RDY = 1;
    if (m_busy) begin m_digit = digit; m_done = 1; m_busy = 0; end
    @(posedge CLK); #1;
    COPROCESSOR_RDY = 0;
    @(posedge CLK); #1;
  endtask

  function automatic logic [31:0] bad_addr();
    return C_ADDR + 32'd12 + 4 * $urandom_range(0, 200);
  endfunction

  // ---------------- stimulus ----------------
  int ni0;
  int op;
  initial begin
    RST = 1; AWADDR = 0; AWVALID = 0; WDATA = 0; WSTRB = 0; WVALID = 0; BREADY = 0;
    ARADDR = 0; ARVALID = 0; RREADY = 0; COPROCESSOR_RDY = 0; INFERED_DIGIT = 0;
    model_reset();
    repeat (3) @(posedge CLK);
    #1;
    check("rst_awready", {63'd0, AWREADY}, 64'd0);
    check("rst_wready", {63'd0, WREADY}, 64'd0);
    check("rst_arready", {63'd0, ARREADY}, 64'd0);
    check("rst_bvalid", {63'd0, BVALID}, 64'd0);
    check("rst_rvalid", {63'd0, RVALID}, 64'd0);
    check("rst_resp", {60'd0, BRESP, RRESP}, 64'd0);
    check("rst_rdata", {32'd0, RDATA}, 64'd0);
    check("rst_new_image", {63'd0, NEW_IMAGE}, 64'd0);
    check("rst_busy", {63'd0, BUSY}, 64'd0);
    check("rst_state", {62'd0, dbg_state}, {62'd0, W_IDLE});
    check_image("rst_image");
    RST = 0;

    // full image, AW-first then W-first
    for (int n = 0; n < WORDS; n++)
      axi_write(4 * n, 32'h04030201, 4'hF, (n < 32) ? 1 : 2, 0);
    check_image("image_full");
    check("image_px5", {56'd0, IMAGE[5*8 +: 8]}, 64'd2);

    // sparse strobes over a zeroed word
    axi_write(32'h0, 32'h0, 4'hF, 0, 0);
    axi_write(32'h0, 32'hAABBCCDD, 4'h5, 0, 0);
    check("strb_px0", {56'd0, IMAGE[7:0]}, 64'hDD);
    check("strb_px1", {56'd0, IMAGE[15:8]}, 64'h00);
    check("strb_px2", {56'd0, IMAGE[23:16]}, 64'hBB);
    check("strb_px3", {56'd0, IMAGE[31:24]}, 64'h00);
    axi_read(32'h0);

    // random image traffic
    for (int i = 0; i < 40; i++) begin
      axi_write(4 * $urandom_range(0, WORDS - 1), $urandom, 4'($urandom_range(0, 15)),
                $urandom_range(0, 2), 0);
      if ($urandom_range(0, 1) == 1) axi_read(4 * $urandom_range(0, WORDS - 1));
    end
    check_image("image_random");

    // start handshake: second request while busy is ignored
    ni0 = ni_count;
    axi_write(C_ADDR, 32'h1, 4'hF, 0, 0);
    axi_write(C_ADDR, 32'h1, 4'hF, 1, 0);
    check("start_pulses", ni_count - ni0, 64'd1);
    check("busy_after_start", {63'd0, BUSY}, 64'd1);
    axi_read(S_ADDR);

    // image writes while busy take effect
    axi_write(32'h40, 32'h55667788, 4'hF, 2, 0);
    check_image("image_while_busy");

    // result latch and read-to-clear
    rdy_pulse(8'd5);
    check("busy_after_result", {63'd0, BUSY}, 64'd0);
    axi_read(R_ADDR);
    axi_read(R_ADDR);
    rdy_pulse(8'd9);
    axi_read(R_ADDR);

    // decode errors and read-only registers
    axi_read(32'h200);
    axi_write(32'h10C, 32'hFFFFFFFF, 4'hF, 0, 0);
    axi_write(S_ADDR, 32'hFFFFFFFF, 4'hF, 1, 0);
    axi_write(R_ADDR, 32'hFFFFFFFF, 4'hF, 2, 0);
    axi_read(S_ADDR);
    axi_read(R_ADDR);
    check_image("image_after_bad");

    // mixed random traffic
    for (int i = 0; i < 80; i++) begin
      op = $urandom_range(0, 8);
      case (op)
        0: axi_write(4 * $urandom_range(0, WORDS - 1), $urandom, 4'($urandom_range(0, 15)),
                     $urandom_range(0, 2), 0);
        1: axi_read(4 * $urandom_range(0, WORDS - 1));
        2: axi_read(S_ADDR);
        3: axi_read(R_ADDR);
        4: axi_write(C_ADDR, 32'($urandom_range(0, 7)), 4'hF, $urandom_range(0, 2), 0);
        5: rdy_pulse(8'($urandom_range(0, 255)));
        6: axi_read(bad_addr());
        7: axi_write(bad_addr(), $urandom, 4'hF, $urandom_range(0, 2), 0);
        default: axi_write(($urandom_range(0, 1) == 1) ? S_ADDR : R_ADDR, $urandom, 4'hF, 0, 0);
      endcase
    end
    check_image("image_mixed");
    check("new_image_count", ni_count, m_ni);
    check("busy_mixed", {63'd0, BUSY}, {63'd0, m_busy});

    // reset while a write response is pending
    axi_write(32'h8, 32'h11223344, 4'hF, 0, 1);
    check("bvalid_pending", {63'd0, BVALID}, 64'd1);
    RST = 1;
    @(posedge CLK); #1;
    RST = 0;
    exp_b_q.delete();
    model_reset();
    check("bvalid_after_rst", {63'd0, BVALID}, 64'd0);
    check("state_after_rst", {62'd0, dbg_state}, {62'd0, W_IDLE});
    check_image("image_after_rst");
    axi_read(R_ADDR);

    // irq enable, result, then clear via CTRL
    axi_write(C_ADDR, 32'h3, 4'hF, 0, 0);
    rdy_pulse(8'd7);
`ifdef S_AXI_IMAGE_IRQ_EN
    check("irq_set", {63'd0, IRQ}, {63'd0, m_done & m_irq_en});
`endif
    axi_read(S_ADDR);
    axi_write(C_ADDR, 32'h6, 4'hF, 0, 0);
`ifdef S_AXI_IMAGE_IRQ_EN
    check("irq_cleared", {63'd0, IRQ}, {63'd0, m_done & m_irq_en});
`endif
    axi_read(S_ADDR);

    repeat (4) @(posedge CLK);
    #1;
    check("bresp_queue_empty", exp_b_q.size(), 64'd0);
    check("rdata_queue_empty", exp_r_q.size(), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
